// File: rtl/core_mem_responder.sv
// Memory-side responder for the single-core matrix multiplier.
// Owns instruction memory (IM) and data memory (DM), gives the core a
// one-cycle registered read of both arrays plus byte writes, and lets a
// host load the arrays before a run and read results back afterwards.
// A three-state controller (LOAD -> RUN -> DUMP -> LOAD) decides who owns
// the arrays and gates the core through core_en.
//
// Host handshake: a request transfers on every rising edge where
// h_valid && h_ready are both high; h_ready is a pure function of state and
// never depends on h_valid. An accepted read returns h_rdata with a one-cycle
// h_rvalid pulse on the following cycle; there is no backpressure on the
// read return path.
module core_mem_responder #(
    parameter int          DM_AW     = 12,
    parameter int          IM_AW     = 8,
    parameter logic [15:0] DONE_ADDR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        dm_wr,
    input  logic        im_wr,
    input  logic [15:0] to_mem,
    output logic [7:0]  dm_in,
    output logic [7:0]  im_in,
    output logic        core_en,
    input  logic        h_valid,
    output logic        h_ready,
    input  logic        h_we,
    input  logic        h_sel,
    input  logic [15:0] h_addr,
    input  logic [7:0]  h_wdata,
    output logic [7:0]  h_rdata,
    output logic        h_rvalid,
    input  logic        h_start,
    output logic        done,
    output logic        err
);

    localparam logic [16:0] DM_DEPTH = 17'(1) << DM_AW;
    localparam logic [16:0] IM_DEPTH = 17'(1) << IM_AW;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0] dm_in_q, dm_in_d;
    logic [7:0] im_in_q, im_in_d;
    logic [7:0] h_rdata_q, h_rdata_d;
    logic       h_rvalid_q, h_rvalid_d;
    logic       err_q, err_d;

    // Storage arrays have no reset so their contents survive rst_n.
    logic [7:0] dm_mem_q [0:(1 << DM_AW) - 1];
    logic [7:0] im_mem_q [0:(1 << IM_AW) - 1];

    logic             dm_we, im_we;
    logic [DM_AW-1:0] dm_widx;
    logic [IM_AW-1:0] im_widx;
    logic [7:0]       mem_wdata;

    logic core_dm_ok, core_im_ok;
    logic host_dm_ok, host_im_ok, host_ok;
    logic core_done_wr;
    logic host_acc;
    logic [7:0] host_rd_word;

    // Only the low byte of core write data is stored.
    logic unused_bits;
    assign unused_bits = ^to_mem[15:8];

    // Range checks compare the full 16-bit address so high bits never alias.
    assign core_dm_ok   = ({1'b0, addr}   < DM_DEPTH);
    assign core_im_ok   = ({1'b0, addr}   < IM_DEPTH);
    assign host_dm_ok   = ({1'b0, h_addr} < DM_DEPTH);
    assign host_im_ok   = ({1'b0, h_addr} < IM_DEPTH);
    assign host_ok      = h_sel ? host_dm_ok : host_im_ok;
    assign core_done_wr = dm_wr && (addr == DONE_ADDR);
    assign host_acc     = h_valid && h_ready;

    // State register; async reset drops core_en immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (h_start)      state_d = ST_RUN;
            ST_RUN:  if (core_done_wr) state_d = ST_DUMP;
            ST_DUMP: if (h_start)      state_d = ST_LOAD;
            default:                   state_d = ST_LOAD;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        core_en = 1'b0;
        done    = 1'b0;
        h_ready = 1'b0;
        case (state_q)
            ST_LOAD: h_ready = 1'b1;
            ST_RUN:  core_en = 1'b1;
            ST_DUMP: begin
                done    = 1'b1;
                h_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Host read word: selected array, or zero when out of range.
    always_comb begin
        host_rd_word = 8'h00;
        if (host_ok) begin
            if (h_sel) host_rd_word = dm_mem_q[h_addr[DM_AW-1:0]];
            else       host_rd_word = im_mem_q[h_addr[IM_AW-1:0]];
        end
    end

    // Datapath: read registers, write enables and the sticky error flag.
    always_comb begin
        dm_in_d    = dm_in_q;
        im_in_d    = im_in_q;
        h_rdata_d  = h_rdata_q;
        h_rvalid_d = 1'b0;
        err_d      = err_q;
        dm_we      = 1'b0;
        im_we      = 1'b0;
        dm_widx    = '0;
        im_widx    = '0;
        mem_wdata  = 8'h00;
        case (state_q)
            ST_RUN: begin
                dm_in_d = core_dm_ok ? dm_mem_q[addr[DM_AW-1:0]] : 8'h00;
                im_in_d = core_im_ok ? im_mem_q[addr[IM_AW-1:0]] : 8'h00;
                // The end-of-run write cycle is a control event, not an
                // out-of-range access, so it never raises err.
                if (!core_done_wr && (!core_dm_ok || !core_im_ok)) begin
                    err_d = 1'b1;
                end
                mem_wdata = to_mem[7:0];
                if (dm_wr && !core_done_wr && core_dm_ok) begin
                    dm_we   = 1'b1;
                    dm_widx = addr[DM_AW-1:0];
                end
                if (im_wr && core_im_ok) begin
                    im_we   = 1'b1;
                    im_widx = addr[IM_AW-1:0];
                end
            end
            ST_LOAD: begin
                if (host_acc) begin
                    if (!host_ok) err_d = 1'b1;
                    if (h_we) begin
                        mem_wdata = h_wdata;
                        if (host_ok && h_sel) begin
                            dm_we   = 1'b1;
                            dm_widx = h_addr[DM_AW-1:0];
                        end
                        if (host_ok && !h_sel) begin
                            im_we   = 1'b1;
                            im_widx = h_addr[IM_AW-1:0];
                        end
                    end else begin
                        h_rvalid_d = 1'b1;
                        h_rdata_d  = host_rd_word;
                    end
                end
            end
            ST_DUMP: begin
                // Host writes are accepted here but have no effect.
                if (host_acc && !h_we) begin
                    h_rvalid_d = 1'b1;
                    h_rdata_d  = host_rd_word;
                    if (!host_ok) err_d = 1'b1;
                end
                if (h_start) err_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered outputs and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_in_q    <= 8'h00;
            im_in_q    <= 8'h00;
            h_rdata_q  <= 8'h00;
            h_rvalid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dm_in_q    <= dm_in_d;
            im_in_q    <= im_in_d;
            h_rdata_q  <= h_rdata_d;
            h_rvalid_q <= h_rvalid_d;
            err_q      <= err_d;
        end
    end

    // Array writes; reads above sample the old contents (read-first).
    always_ff @(posedge clk) begin
        if (dm_we) dm_mem_q[dm_widx] <= mem_wdata;
        if (im_we) im_mem_q[im_widx] <= mem_wdata;
    end

    assign dm_in    = dm_in_q;
    assign im_in    = im_in_q;
    assign h_rdata  = h_rdata_q;
    assign h_rvalid = h_rvalid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Self-checking bench for core_mem_responder: host load/readback, core
// read/write in RUN, end-of-run write, DUMP readback, range errors and
// reset in the middle of a run.
module tb_core_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        dm_wr;
  logic        im_wr;
  logic [15:0] to_mem;
  logic [7:0]  dm_in;
  logic [7:0]  im_in;
  logic        core_en;
  logic        h_valid;
  logic        h_ready;
  logic        h_we;
  logic        h_sel;
  logic [15:0] h_addr;
  logic [7:0]  h_wdata;
  logic [7:0]  h_rdata;
  logic        h_rvalid;
  logic        h_start;
  logic        done;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];

  core_mem_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .dm_wr    (dm_wr),
    .im_wr    (im_wr),
    .to_mem   (to_mem),
    .dm_in    (dm_in),
    .im_in    (im_in),
    .core_en  (core_en),
    .h_valid  (h_valid),
    .h_ready  (h_ready),
    .h_we     (h_we),
    .h_sel    (h_sel),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_rdata  (h_rdata),
    .h_rvalid (h_rvalid),
    .h_start  (h_start),
    .done     (done),
    .err      (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic host_write(input logic sel, input logic [15:0] a, input logic [7:0] d);
    h_valid = 1'b1; h_we = 1'b1; h_sel = sel; h_addr = a; h_wdata = d;
    check_eq("h_ready_wr", {15'd0, h_ready}, 16'd1);
    tick();
  endtask

  task automatic host_read(input logic sel, input logic [15:0] a, input logic [7:0] exp);
    h_valid = 1'b1; h_we = 1'b0; h_sel = sel; h_addr = a;
    exp_q.push_back(exp);
    tick();
  endtask

  task automatic host_idle();
    h_valid = 1'b0; h_we = 1'b0;
  endtask

  task automatic core_cycle(input logic [15:0] a, input logic dw, input logic iw, input logic [15:0] d);
    addr = a; dm_wr = dw; im_wr = iw; to_mem = d;
    tick();
    dm_wr = 1'b0; im_wr = 1'b0;
  endtask

  // scoreboard: every h_rvalid pulse must match the oldest expected word
  always @(negedge clk) begin
    if (h_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL h_rvalid_unexpected got=1 exp=0");
      end else begin
        check_eq("h_rdata", {8'd0, h_rdata}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] im_init [4];
    im_init[0] = 8'h11; im_init[1] = 8'h22; im_init[2] = 8'h33; im_init[3] = 8'h44;

    rst_n = 1'b0; addr = '0; dm_wr = 1'b0; im_wr = 1'b0; to_mem = '0;
    h_valid = 1'b0; h_we = 1'b0; h_sel = 1'b0; h_addr = '0; h_wdata = '0; h_start = 1'b0;
    repeat (3) tick();

    // reset state
    check_eq("rst_core_en",  {15'd0, core_en},  16'd0);
    check_eq("rst_done",     {15'd0, done},     16'd0);
    check_eq("rst_err",      {15'd0, err},      16'd0);
    check_eq("rst_h_rvalid", {15'd0, h_rvalid}, 16'd0);
    check_eq("rst_dm_in",    {8'd0, dm_in},     16'd0);
    check_eq("rst_im_in",    {8'd0, im_in},     16'd0);
    check_eq("rst_h_rdata",  {8'd0, h_rdata},   16'd0);
    check_eq("rst_h_ready",  {15'd0, h_ready},  16'd1);
    rst_n = 1'b1;
    tick();

    // host load with h_valid held, then back-to-back readback
    for (int i = 0; i < 4; i++) host_write(1'b0, 16'(i), im_init[i]);
    host_write(1'b0, 16'd5, 8'h66);
    host_write(1'b1, 16'd5, 8'hA5);
    for (int i = 0; i < 4; i++) host_read(1'b0, 16'(i), im_init[i]);
    host_read(1'b1, 16'd5, 8'hA5);
    host_idle();
    tick();
    check_eq("load_core_en", {15'd0, core_en}, 16'd0);

    // h_start together with a host read: read served, then RUN
    h_start = 1'b1;
    host_read(1'b0, 16'd2, 8'h33);
    h_start = 1'b0;
    host_idle();
    check_eq("run_core_en", {15'd0, core_en}, 16'd1);
    check_eq("run_h_ready", {15'd0, h_ready}, 16'd0);
    check_eq("run_done",    {15'd0, done},    16'd0);

    // core read with one-cycle latency
    core_cycle(16'd5, 1'b0, 1'b0, 16'h0);
    check_eq("run_dm_rd5", {8'd0, dm_in}, 16'h00A5);
    check_eq("run_im_rd5", {8'd0, im_in}, 16'h0066);

    // h_start and a host request in RUN are both ignored
    h_start = 1'b1; h_valid = 1'b1; h_we = 1'b0; h_sel = 1'b1; h_addr = 16'd5;
    tick();
    h_start = 1'b0;
    host_idle();
    check_eq("run_hstart_ign", {15'd0, core_en}, 16'd1);

    // read-during-write returns old data, then new data
    core_cycle(16'd5, 1'b1, 1'b0, 16'h12C3);
    check_eq("rdw_old", {8'd0, dm_in}, 16'h00A5);
    core_cycle(16'd5, 1'b0, 1'b0, 16'h0);
    check_eq("rdw_new", {8'd0, dm_in}, 16'h00C3);

    // both strobes write both arrays
    core_cycle(16'd8, 1'b1, 1'b1, 16'h3477);
    core_cycle(16'd8, 1'b0, 1'b0, 16'h0);
    check_eq("both_dm", {8'd0, dm_in}, 16'h0077);
    check_eq("both_im", {8'd0, im_in}, 16'h0077);
    check_eq("err_clean", {15'd0, err}, 16'd0);

    // out-of-range core read and write (no aliasing onto DM[5])
    core_cycle(16'h1000, 1'b0, 1'b0, 16'h0);
    check_eq("oor_dm_in", {8'd0, dm_in}, 16'd0);
    check_eq("oor_im_in", {8'd0, im_in}, 16'd0);
    check_eq("oor_err",   {15'd0, err},  16'd1);
    core_cycle(16'h1005, 1'b1, 1'b0, 16'h00EE);
    core_cycle(16'd5, 1'b0, 1'b0, 16'h0);
    check_eq("no_alias", {8'd0, dm_in}, 16'h00C3);
    check_eq("err_sticky", {15'd0, err}, 16'd1);

    // end-of-run write
    core_cycle(16'hFFFF, 1'b1, 1'b0, 16'h00BB);
    addr = 16'd0;
    check_eq("dump_core_en", {15'd0, core_en}, 16'd0);
    check_eq("dump_done",    {15'd0, done},    16'd1);
    check_eq("dump_h_ready", {15'd0, h_ready}, 16'd1);

    // DUMP readback, discarded write, out-of-range read
    host_read(1'b1, 16'd5, 8'hC3);
    host_write(1'b1, 16'd5, 8'hFF);
    host_read(1'b1, 16'd5, 8'hC3);
    host_read(1'b1, 16'hFFFF, 8'h00);
    host_read(1'b1, 16'd8, 8'h77);
    host_idle();
    tick();

    // h_start in DUMP returns to LOAD and clears flags
    h_start = 1'b1;
    tick();
    h_start = 1'b0;
    check_eq("load2_done",    {15'd0, done},    16'd0);
    check_eq("load2_err",     {15'd0, err},     16'd0);
    check_eq("load2_core_en", {15'd0, core_en}, 16'd0);
    check_eq("load2_h_ready", {15'd0, h_ready}, 16'd1);
    host_read(1'b0, 16'd8, 8'h77);
    host_idle();

    // reset in the middle of a run
    h_start = 1'b1;
    tick();
    h_start = 1'b0;
    core_cycle(16'd7, 1'b1, 1'b0, 16'h005A);
    check_eq("run2_core_en", {15'd0, core_en}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_core_en", {15'd0, core_en}, 16'd0);
    check_eq("async_h_ready", {15'd0, h_ready}, 16'd1);
    check_eq("async_dm_in",   {8'd0, dm_in},    16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    host_read(1'b1, 16'd7, 8'h5A);
    host_read(1'b0, 16'd0, 8'h11);
    host_idle();
    repeat (3) tick();

    check_eq("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
